// File: rtl/print_line_packetiser.sv
// Turns one accepted thermal-head dot line into a packet on the narrow output stream:
// a header word {line count, motor steps since the previous line}, then the line in WORD_WIDTH slices.
module print_line_packetiser #(
    parameter int HEAD_WIDTH = 384,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  step_pulse,
    input  logic                  line_valid,
    output logic                  line_ready,
    input  logic [HEAD_WIDTH-1:0] line_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int WORDS = HEAD_WIDTH / WORD_WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [15:0]           line_cnt_q, line_cnt_d;
    logic [15:0]           step_cnt_q, step_cnt_d;
    logic [HEAD_WIDTH-1:0] buf_q, buf_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  line_ready_q, busy_q;
    logic                  accept, fire;

    assign accept = line_valid && line_ready_q;
    assign fire   = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        line_cnt_d  = line_cnt_q;
        step_cnt_d  = step_cnt_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        // Step count saturates so a long paper feed reads as 0xFFFF, never a small wrapped value.
        if (step_pulse && (step_cnt_q != 16'hFFFF)) begin
            step_cnt_d = step_cnt_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d            = line_data;
                    out_data_d       = '0;
                    out_data_d[31:0] = {line_cnt_q, step_cnt_q};
                    line_cnt_d       = line_cnt_q + 16'd1;
                    step_cnt_d       = {15'd0, step_pulse};
                    out_valid_d      = 1'b1;
                    out_last_d       = 1'b0;
                    state_d          = HEADER;
                end
            end
            HEADER: begin
                if (fire) begin
                    word_idx_d = '0;
                    out_data_d = buf_q[0 +: WORD_WIDTH];
                    out_last_d = (LAST_IDX == '0);
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (fire) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        out_data_d = buf_q[word_idx_d*WORD_WIDTH +: WORD_WIDTH];
                        out_last_d = (word_idx_d == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            line_cnt_q   <= '0;
            step_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            line_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            line_cnt_q   <= line_cnt_d;
            step_cnt_q   <= step_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            // Ready waits one idle cycle after a packet ends, giving the 2-cycle inter-packet gap.
            line_ready_q <= (state_d == IDLE) && (state_q == IDLE) && enable;
            busy_q       <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign line_ready = line_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_print_line_packetiser.sv
// Directed bench for print_line_packetiser: header contents, data slicing, gaps,
// stall stability, step saturation, reset abort and enable gating.
module tb_print_line_packetiser;
    logic         clk = 1'b0;
    logic         reset, enable, step_pulse, line_valid, out_ready;
    logic         line_ready, out_valid, out_last, busy;
    logic [383:0] line_data;
    logic [31:0]  out_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] words [0:31];
    logic        lasts [0:31];
    int          pkt_n;
    int          stall_bad;
    int          lr_bad;

    print_line_packetiser #(.HEAD_WIDTH(384), .WORD_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .enable(enable), .step_pulse(step_pulse),
        .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a line and wait (bounded) for it to be taken; header is visible on return.
    task automatic send_line(input string tag, input logic [383:0] d);
        bit taken;
        taken      = 1'b0;
        line_data  = d;
        line_valid = 1'b1;
        for (int c = 0; c < 20 && !taken; c++) begin
            if (line_ready) taken = 1'b1;
            tick();
        end
        line_valid = 1'b0;
        chk({tag, "_accepted"}, taken, 1'b1);
    endtask

    // Drain one packet; with rnd set out_ready toggles randomly and stalled words are watched.
    task automatic collect(input bit rnd);
        bit          done, stalled;
        logic [31:0] hd;
        logic        hl;
        pkt_n     = 0;
        stall_bad = 0;
        lr_bad    = 0;
        done      = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = 1'b0;
            if (line_ready) lr_bad++;
            if (out_valid) begin
                if (out_ready) begin
                    if (pkt_n < 32) begin
                        words[pkt_n] = out_data;
                        lasts[pkt_n] = out_last;
                    end
                    pkt_n++;
                    if (out_last) done = 1'b1;
                end else begin
                    stalled = 1'b1;
                    hd      = out_data;
                    hl      = out_last;
                end
            end
            tick();
            if (stalled && (!out_valid || out_data !== hd || out_last !== hl)) stall_bad++;
        end
        out_ready = 1'b0;
        chk("pkt_done", done, 1'b1);
    endtask

    task automatic check_pkt(input string tag, input logic [31:0] hdr, input logic [383:0] ln);
        int          wb;
        logic [12:0] lm;
        wb = 0;
        lm = '0;
        chk({tag, "_len"}, pkt_n, 13);
        chk({tag, "_hdr"}, words[0], hdr);
        for (int k = 0; k < 12; k++) if (words[k+1] !== ln[k*32 +: 32]) wb++;
        for (int k = 0; k < 13; k++) lm[k] = lasts[k];
        chk({tag, "_data"}, wb, 0);
        chk({tag, "_last"}, lm, 13'h1000);
        chk({tag, "_ready_low"}, lr_bad, 0);
        chk({tag, "_idle_after"}, out_valid, 1'b0);
    endtask

    logic [383:0] la, lb, lc;
    logic [31:0]  vd [0:79];
    logic         vv [0:79];
    logic         vl [0:79];

    initial begin
        int acc, rb, wc, ia, ib, f, mism;
        reset = 1'b1; enable = 1'b0; step_pulse = 1'b0; line_valid = 1'b0;
        out_ready = 1'b0; line_data = '0;
        tick(); tick();
        chk("rst_line_ready", line_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        reset = 1'b0; enable = 1'b1;
        tick();
        chk("ready_after_rst", line_ready, 1'b1);

        // 1: three steps, dots 0 and 383 set
        step_pulse = 1'b1;
        tick(); tick(); tick();
        step_pulse = 1'b0;
        la = '0; la[0] = 1'b1; la[383] = 1'b1;
        send_line("t1", la);
        chk("t1_hdr_now", out_data, 32'h0000_0003);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready_low", line_ready, 1'b0);
        collect(1'b0);
        check_pkt("t1", 32'h0000_0003, la);
        chk("t1_word0", words[1], 32'h0000_0001);
        chk("t1_word11", words[12], 32'h8000_0000);

        // 2: two lines back-to-back, line held valid
        for (int k = 0; k < 12; k++) begin
            la[k*32 +: 32] = 32'hA000_0000 + k;
            lb[k*32 +: 32] = 32'hB000_0000 + k;
        end
        tick();
        out_ready = 1'b1; line_valid = 1'b1; line_data = la; acc = 0; rb = 0;
        for (int i = 0; i < 80; i++) begin
            vv[i] = out_valid; vd[i] = out_data; vl[i] = out_last;
            if (line_ready && busy) rb++;
            if (line_ready && line_valid) acc++;
            tick();
            if (acc == 1) line_data = lb;
            if (acc == 2) line_valid = 1'b0;
        end
        out_ready = 1'b0;
        wc = 0; ia = -1; ib = -1; f = -1; mism = 0;
        for (int i = 0; i < 80; i++) begin
            if (vv[i]) begin
                if (f < 0) f = i;
                if (ia >= 0 && ib < 0) ib = i;
                if (wc == 0  && vd[i] !== 32'h0001_0000) mism++;
                if (wc == 13 && vd[i] !== 32'h0002_0000) mism++;
                if (wc >= 1  && wc <= 12 && vd[i] !== la[(wc-1)*32 +: 32]) mism++;
                if (wc >= 14 && wc <= 25 && vd[i] !== lb[(wc-14)*32 +: 32]) mism++;
                if (vl[i] && ia < 0) ia = i;
                wc++;
            end
        end
        chk("t2_word_count", wc, 26);
        chk("t2_contents", mism, 0);
        chk("t2_no_bubbles", ia - f, 12);
        chk("t2_gap", ib - ia - 1, 2);
        chk("t2_ready_busy", rb, 0);

        // 3: random backpressure over a full packet
        for (int k = 0; k < 12; k++) lc[k*32 +: 32] = $urandom;
        tick();
        send_line("t3", lc);
        collect(1'b1);
        check_pkt("t3", 32'h0003_0000, lc);
        chk("t3_stall_stable", stall_bad, 0);

        // 4: step count saturation, pulse in the accept cycle
        step_pulse = 1'b1;
        repeat (70000) tick();
        send_line("t4a", la);
        step_pulse = 1'b0;
        collect(1'b0);
        check_pkt("t4a", 32'h0004_FFFF, la);
        send_line("t4b", lb);
        collect(1'b0);
        check_pkt("t4b", 32'h0005_0001, lb);

        // 5: reset after word 5
        send_line("t5", lc);
        out_ready = 1'b1;
        repeat (7) tick();
        chk("t5_word6_shown", out_data, lc[6*32 +: 32]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid_cleared", out_valid, 1'b0);
        chk("t5_data_cleared", out_data, 32'h0);
        chk("t5_busy_cleared", busy, 1'b0);
        out_ready = 1'b0;
        tick();
        chk("t5_ready_back", line_ready, 1'b1);
        send_line("t5b", la);
        collect(1'b0);
        check_pkt("t5b", 32'h0000_0000, la);

        // 6: enable gating
        enable = 1'b0;
        tick();
        chk("t6_ready_off", line_ready, 1'b0);
        line_valid = 1'b1; line_data = lb;
        tick(); tick(); tick();
        chk("t6_no_packet", out_valid, 1'b0);
        chk("t6_not_busy", busy, 1'b0);
        chk("t6_ready_still_off", line_ready, 1'b0);
        line_valid = 1'b0;
        enable = 1'b1;
        tick();
        send_line("t6", lb);
        enable = 1'b0;
        collect(1'b0);
        check_pkt("t6", 32'h0001_0000, lb);
        tick(); tick();
        chk("t6_ready_after", line_ready, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
